// File: rtl/opm_write_seq.sv
// OPM (YM2151) register write sequencer.
// Requests {addr,data} are queued in a small FIFO, then written out over the OPM bus:
// poll busy (status read), address write, idle gap, data write. All bus timing is
// counted in ce pulses. Bus strobes are registered from the FSM next state.
// Optional build macro OPM_WRITE_SEQ_TIMEOUT_EN adds a per-request poll limit and a
// sticky timeout_err flag. Without it polling never gives up and timeout_err is 0.
module opm_write_seq #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned GAP_CE        = 4,
  parameter int unsigned TIMEOUT_POLLS = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce,
  input  logic                          req_valid,
  input  logic [7:0]                    req_addr,
  input  logic [7:0]                    req_data,
  output logic                          req_ready,
  output logic                          opm_cs_n,
  output logic                          opm_wr_n,
  output logic                          opm_rd_n,
  output logic                          opm_a0,
  output logic [7:0]                    opm_d,
  input  logic [7:0]                    opm_q,
  output logic                          pending,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DepthL  = LW'(FIFO_DEPTH);
  localparam logic [3:0]    GapLast = 4'(GAP_CE - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPoll = 3'd1;
  localparam logic [2:0] StAddr = 3'd2;
  localparam logic [2:0] StGap  = 3'd3;
  localparam logic [2:0] StData = 3'd4;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;
  logic [15:0]   fifo_head;

  assign req_ready = (level_q < DepthL);
  assign push      = req_valid && req_ready;
  assign fifo_head = mem_q[rptr_q];
  assign level     = level_q;

  // Storage array; contents are don't-care after reset since pointers restart.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {req_addr, req_data};
    end
  end

  // Occupancy: simultaneous push and pop leave the level unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;     // ce pulses spent in the current bus phase
  logic        rel_q, rel_d;     // POLL: strobes released for one ce between reads
  logic [15:0] hold_q, hold_d;   // request being written out
  logic        busy;

  assign busy    = opm_q[7];
  assign pending = (level_q != '0) || (state_q != StIdle);

`ifdef OPM_WRITE_SEQ_TIMEOUT_EN
  localparam logic [7:0] PollLast = 8'(TIMEOUT_POLLS - 1);
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic       tmo_set;
  logic       err_q, err_d;
`endif

  // Next-state logic; every transition except IDLE->POLL waits for ce.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    hold_d  = hold_q;
    pop     = 1'b0;
`ifdef OPM_WRITE_SEQ_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
    tmo_set    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          hold_d  = fifo_head;
          cnt_d   = '0;
          rel_d   = 1'b0;
`ifdef OPM_WRITE_SEQ_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
          state_d = StPoll;
        end
      end
      StPoll: begin
        if (ce) begin
          if (rel_q) begin
            rel_d = 1'b0;
            cnt_d = '0;
          end else if (cnt_q == 4'd0) begin
            cnt_d = 4'd1;
          end else begin
            // Second ce of the read: busy flag is sampled here.
            cnt_d = '0;
            if (!busy) begin
              state_d = StAddr;
            end else begin
`ifdef OPM_WRITE_SEQ_TIMEOUT_EN
              if (poll_cnt_q == PollLast) begin
                tmo_set = 1'b1;
                state_d = StAddr;
              end else begin
                poll_cnt_d = poll_cnt_q + 8'd1;
                rel_d      = 1'b1;
              end
`else
              rel_d = 1'b1;
`endif
            end
          end
        end
      end
      StAddr: begin
        if (ce) begin
          if (cnt_q == 4'd1) begin
            cnt_d   = '0;
            state_d = StGap;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StGap: begin
        if (ce) begin
          if (cnt_q == GapLast) begin
            cnt_d   = '0;
            state_d = StData;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (ce) begin
          if (cnt_q == 4'd1) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        rel_d   = 1'b0;
      end
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rel_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus outputs, decoded from the next state so they line up with the FSM and
  // come straight out of flops. Read and write strobes are mutually exclusive
  // by construction and cs_n is only low while one of them is.
  // ---------------------------------------------------------------------------
  logic       cs_n_q, wr_n_q, rd_n_q, a0_q;
  logic       cs_n_d, wr_n_d, rd_n_d, a0_d;
  logic [7:0] d_q, d_d;

  // Decode bus levels for the upcoming state.
  always_comb begin
    cs_n_d = 1'b1;
    wr_n_d = 1'b1;
    rd_n_d = 1'b1;
    a0_d   = 1'b0;
    d_d    = d_q;
    case (state_d)
      StPoll: begin
        if (!rel_d) begin
          cs_n_d = 1'b0;
          rd_n_d = 1'b0;
        end
      end
      StAddr: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        d_d    = hold_d[15:8];
      end
      StData: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        a0_d   = 1'b1;
        d_d    = hold_d[7:0];
      end
      default: ;
    endcase
  end

  // Output registers; reset releases the strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      rd_n_q <= 1'b1;
      a0_q   <= 1'b0;
      d_q    <= '0;
    end else begin
      cs_n_q <= cs_n_d;
      wr_n_q <= wr_n_d;
      rd_n_q <= rd_n_d;
      a0_q   <= a0_d;
      d_q    <= d_d;
    end
  end

  assign opm_cs_n = cs_n_q;
  assign opm_wr_n = wr_n_q;
  assign opm_rd_n = rd_n_q;
  assign opm_a0   = a0_q;
  assign opm_d    = d_q;

  // ---------------------------------------------------------------------------
  // Timeout flag
  // ---------------------------------------------------------------------------
`ifdef OPM_WRITE_SEQ_TIMEOUT_EN
  // A timeout set wins over a clear on the same edge.
  always_comb begin
    err_d = err_q;
    if (tmo_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Poll counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = err_clr | (TIMEOUT_POLLS == 0);
  assign timeout_err = 1'b0;
`endif

  // Only the busy bit of the status byte is meaningful.
  logic unused_status;
  assign unused_status = ^opm_q[6:0];

endmodule

// File: tb/tb_opm_write_seq.sv
// Self-checking bench for opm_write_seq: directed steps with a write scoreboard
// and a bus monitor measuring strobe widths in ce pulses.
module tb_opm_write_seq;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned GAP   = 4;
`ifdef OPM_WRITE_SEQ_TIMEOUT_EN
  localparam int unsigned TMO        = 3;
  localparam int unsigned BUSY_POLLS = 2;
`else
  localparam int unsigned TMO        = 255;
  localparam int unsigned BUSY_POLLS = 3;
`endif

  logic       clk;
  logic       reset;
  logic       ce;
  logic       req_valid;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       req_ready;
  logic       opm_cs_n, opm_wr_n, opm_rd_n, opm_a0;
  logic [7:0] opm_d;
  logic [7:0] opm_q;
  logic       pending;
  logic [4:0] level;
  logic       timeout_err;
  logic       err_clr;

  int checks;
  int failures;
  int rd_done;
  int reads_before_addr;
  int writes_done;
  int bus_events;
  int busy_polls;
  bit busy_hold;
  logic [15:0] exp_q[$];

  opm_write_seq #(
    .FIFO_DEPTH    (DEPTH),
    .GAP_CE        (GAP),
    .TIMEOUT_POLLS (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .opm_cs_n    (opm_cs_n),
    .opm_wr_n    (opm_wr_n),
    .opm_rd_n    (opm_rd_n),
    .opm_a0      (opm_a0),
    .opm_d       (opm_d),
    .opm_q       (opm_q),
    .pending     (pending),
    .level       (level),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ce: one clk wide, every 4th clk.
  initial begin
    int cyc;
    cyc = 0;
    ce  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      ce = (cyc % 4 == 0);
    end
  end

  // OPM status model: busy for the first busy_polls reads of a request, or always.
  initial begin
    opm_q = 8'h7F;
    forever begin
      @(negedge clk);
      opm_q = (busy_hold || rd_done < busy_polls) ? 8'h80 : 8'h7F;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and scoreboard consumer.
  initial begin
    logic       p_wr, p_rd, p_cs;
    int         wr_ce, rd_ce, gap_ce;
    logic [7:0] cur_addr;
    logic [15:0] e;
    p_wr = 1'b1; p_rd = 1'b1; p_cs = 1'b1;
    wr_ce = 0; rd_ce = 0; gap_ce = 0; cur_addr = '0;
    rd_done = 0; reads_before_addr = 0; writes_done = 0; bus_events = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        rd_done = 0; wr_ce = 0; rd_ce = 0; gap_ce = 0;
      end else begin
        if (ce) begin
          if (!p_wr) wr_ce++;
          if (!p_rd) rd_ce++;
          if (p_cs)  gap_ce++;
        end
        chk("rd_wr_exclusive", 32'(opm_rd_n | opm_wr_n), 1);
        if (opm_rd_n && opm_wr_n) chk("cs_released", 32'(opm_cs_n), 1);
        if (p_rd && !opm_rd_n) begin
          bus_events++;
          rd_ce = 0;
          chk("rd_cs_a0", 32'({opm_cs_n, opm_a0}), 0);
        end
        if (!p_rd && opm_rd_n) begin
          chk("rd_width_ce", 32'(rd_ce), 2);
          rd_done++;
        end
        if (p_wr && !opm_wr_n) begin
          bus_events++;
          wr_ce = 0;
          chk("wr_cs", 32'(opm_cs_n), 0);
          if (!opm_a0) begin
            cur_addr          = opm_d;
            reads_before_addr = rd_done;
            rd_done           = 0;
          end else begin
            chk("gap_ce", 32'(gap_ce), GAP);
            chk("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("write_order", 32'({cur_addr, opm_d}), 32'(e));
            end
            writes_done++;
          end
        end
        if (!p_wr && opm_wr_n) begin
          chk("wr_width_ce", 32'(wr_ce), 2);
          gap_ce = 0;
        end
      end
      p_wr = opm_wr_n;
      p_rd = opm_rd_n;
      p_cs = opm_cs_n;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("push_accepted", 32'(req_ready), 1);
    if (req_ready) exp_q.push_back({a, d});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((pending || exp_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(!pending && exp_q.size() == 0), 1);
  endtask

  initial begin
    int w0, e0, n;
    checks = 0; failures = 0;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; err_clr = 1'b0;
    busy_hold = 1'b0; busy_polls = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", 32'({opm_cs_n, opm_wr_n, opm_rd_n}), 3'b111);
    chk("rst_a0_d", 32'({opm_a0, opm_d}), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_timeout", 32'(timeout_err), 0);
    @(negedge clk);
    reset = 1'b0;

    // Single write.
    push(8'h20, 8'hC7);
    chk("single_pending_busy", 32'(pending), 1);
    wait_idle(2000);
    chk("single_writes", 32'(writes_done), 1);
    chk("single_reads", 32'(reads_before_addr), 1);
    chk("single_level", 32'(level), 0);

    // Busy wait.
    busy_polls = BUSY_POLLS;
    push(8'h31, 8'h5A);
    wait_idle(3000);
    chk("busy_reads", 32'(reads_before_addr), BUSY_POLLS + 1);
    chk("busy_no_timeout", 32'(timeout_err), 0);
    busy_polls = 0;

    // Full FIFO with pointer wrap.
    busy_hold = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i), 8'(8'hA0 + i));
    chk("full_level", 32'(level), DEPTH);
    chk("full_ready", 32'(req_ready), 0);
    w0 = writes_done;
    fork
      push(8'h60, 8'hEE);
      begin
        repeat (30) @(negedge clk);
        chk("full_hold_level", 32'(level), DEPTH);
        chk("full_no_write", 32'(writes_done), 32'(w0));
        busy_hold = 1'b0;
      end
    join
    chk("refill_level", 32'(level), DEPTH);
    wait_idle(8000);
    chk("full_writes", 32'(writes_done), 32'(w0 + 18));

    // Reset during the data strobe.
    push(8'h70, 8'h11);
    push(8'h71, 8'h22);
    push(8'h72, 8'h33);
    n = 0;
    while (!(!opm_wr_n && opm_a0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("data_phase_seen", 32'(!opm_wr_n && opm_a0), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_strobes", 32'({opm_cs_n, opm_wr_n, opm_rd_n}), 3'b111);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_pending", 32'(pending), 0);
    chk("mid_rst_ready", 32'(req_ready), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    e0 = bus_events;
    repeat (200) @(negedge clk);
    chk("quiet_after_reset", 32'(bus_events), 32'(e0));
    chk("quiet_pending", 32'(pending), 0);
    w0 = writes_done;
    push(8'h7A, 8'h99);
    wait_idle(2000);
    chk("post_rst_write", 32'(writes_done), 32'(w0 + 1));

`ifdef OPM_WRITE_SEQ_TIMEOUT_EN
    // Timeout, clear, and set-beats-clear.
    busy_hold = 1'b1;
    push(8'h55, 8'h66);
    wait_idle(3000);
    chk("tmo_set", 32'(timeout_err), 1);
    chk("tmo_reads", 32'(reads_before_addr), TMO);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("tmo_cleared", 32'(timeout_err), 0);
    err_clr = 1'b1;
    push(8'h56, 8'h67);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (opm_wr_n && n < 3000);
    chk("tmo_set_wins", 32'(timeout_err), 1);
    @(negedge clk) err_clr = 1'b0;
    wait_idle(3000);
    busy_hold = 1'b0;
`endif

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
